// File: rtl/n1_pkg.sv
// Shared opcodes, sequencer state encoding and result width for the n1 neuron
// command sequencer.
package n1_pkg;

  localparam int unsigned ACC_W = 16;

  localparam logic [3:0] OP_LOAD_W  = 4'h1;
  localparam logic [3:0] OP_LOAD_X  = 4'h2;
  localparam logic [3:0] OP_RUN     = 4'h3;
  localparam logic [3:0] OP_READ    = 4'h4;
  localparam logic [3:0] OP_CLR_ERR = 4'h5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_OUT_HI,
    S_OUT_LO
  } state_t;

endpackage

// File: rtl/n1_seq_timer.sv
// MAC completion watchdog for n1_seq; instantiated only when N1_TIMEOUT_EN is
// defined.
module n1_seq_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic run,
  output logic expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= run ? cnt + 1'b1 : '0;
    end
  end

  // Flagged one count early so the sequencer leaves WAIT on the edge where the
  // count would reach TIMEOUT.
  assign expired = run && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/n1_seq.sv
// Byte-command sequencer for the n1 neuron: load, run and read operations.
// Optional MAC timeout with sticky err is enabled by defining N1_TIMEOUT_EN.
module n1_seq
  import n1_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned ACC_W   = n1_pkg::ACC_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_byte,
  output logic             cmd_ready,
  output logic             w_we,
  output logic             x_we,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data,
  output logic             mac_start,
  input  logic             mac_done,
  input  logic [ACC_W-1:0] mac_result,
  output logic             res_valid,
  output logic [7:0]       res_byte,
  input  logic             res_ready,
  output logic             bus_oe,
  output logic             busy,
  output logic             err
);

  state_t           state, state_n;
  logic             armed;
  logic             sel_x;
  logic [3:0]       cnt;
  logic [AW-1:0]    addr;
  logic [ACC_W-1:0] result;
  logic             take;
  logic             timeout;
  logic [3:0]       op;

  assign op   = cmd_byte[7:4];
  assign take = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = ena && armed;
        if (cmd_valid && ena && armed) begin
          if (op == OP_LOAD_W || op == OP_LOAD_X) state_n = S_LOAD;
          else if (op == OP_RUN)                  state_n = S_START;
          else if (op == OP_READ)                 state_n = S_OUT_HI;
        end
      end
      S_LOAD: begin
        cmd_ready = ena && armed;
        if (cmd_valid && ena && armed && cnt == '0) state_n = S_IDLE;
      end
      S_START: if (ena) state_n = S_WAIT;
      S_WAIT:  if (ena && (mac_done || timeout)) state_n = S_IDLE;
      S_OUT_HI: if (ena && res_ready) state_n = S_OUT_LO;
      S_OUT_LO: if (ena && res_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      sel_x  <= 1'b0;
      cnt    <= '0;
      addr   <= '0;
      result <= '0;
    end else if (ena) begin
      armed <= 1'b1;
      if (state == S_IDLE && take && (op == OP_LOAD_W || op == OP_LOAD_X)) begin
        cnt   <= cmd_byte[3:0];
        addr  <= '0;
        sel_x <= (op == OP_LOAD_X);
      end else if (state == S_LOAD && take) begin
        cnt  <= cnt - 1'b1;
        addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
      end
      if (state == S_WAIT) begin
        if (mac_done)     result <= mac_result;
        else if (timeout) result <= '1;
      end
    end
  end

`ifdef N1_TIMEOUT_EN
  n1_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .run     (state == S_WAIT),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (ena) begin
      if (state == S_WAIT && !mac_done && timeout)             err <= 1'b1;
      else if (state == S_IDLE && take && op == OP_CLR_ERR)    err <= 1'b0;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Operand writes are combinational from the accepted byte: zero latency.
  assign w_we      = take && state == S_LOAD && !sel_x;
  assign x_we      = take && state == S_LOAD && sel_x;
  assign wr_addr   = addr;
  assign wr_data   = cmd_byte;
  assign mac_start = ena && state == S_START;
  assign res_valid = (state == S_OUT_HI) || (state == S_OUT_LO);
  assign res_byte  = (state == S_OUT_HI) ? result[15:8] :
                     (state == S_OUT_LO) ? result[7:0]  : 8'h00;
  assign bus_oe    = res_valid;
  assign busy      = state != S_IDLE;

endmodule

// File: tb/tb_n1_seq.sv
// Directed self-checking bench for n1_seq; covers the timeout path when built
// with N1_TIMEOUT_EN.
module tb_n1_seq;

  logic        clk = 1'b0;
  logic        rst_n, ena, cmd_valid, res_ready, mac_done;
  logic [7:0]  cmd_byte;
  logic [15:0] mac_result;
  logic        cmd_ready, w_we, x_we, mac_start, res_valid, bus_oe, busy, err;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data, res_byte;

  int errors = 0;
  int checks = 0;
  int mac_starts = 0;
  bit mac_auto = 1'b1;
  int n;

  n1_seq #(
    .DEPTH   (16),
    .AW      (4),
    .ACC_W   (16),
    .TIMEOUT (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .cmd_ready  (cmd_ready),
    .w_we       (w_we),
    .x_we       (x_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mac_start  (mac_start),
    .mac_done   (mac_done),
    .mac_result (mac_result),
    .res_valid  (res_valid),
    .res_byte   (res_byte),
    .res_ready  (res_ready),
    .bus_oe     (bus_oe),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    #1;
  endtask

  task automatic load_seq(input logic [7:0] cmd, input int nbytes, input logic [7:0] base);
    logic is_x;
    is_x = (cmd[7:4] == 4'h2);
    drive(cmd);
    check("load_cmd_ready", cmd_ready, 1);
    step();
    for (int i = 0; i < nbytes; i++) begin
      drive(base + 8'(i));
      check("load_w_we", w_we, !is_x);
      check("load_x_we", x_we, is_x);
      check("load_addr", wr_addr, i % 16);
      check("load_data", wr_data, base + 8'(i));
      step();
    end
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic read_pair(input logic [15:0] exp, input int stall);
    drive(8'h40);
    step();
    cmd_valid = 1'b0;
    #1;
    check("rd_hi_valid", res_valid, 1);
    check("rd_hi_oe", bus_oe, 1);
    check("rd_cmd_ready", cmd_ready, 0);
    check("rd_hi_byte", res_byte, exp[15:8]);
    for (int i = 0; i < stall; i++) begin
      step();
      check("rd_stall_byte", res_byte, exp[15:8]);
      check("rd_stall_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    step();
    check("rd_lo_byte", res_byte, exp[7:0]);
    check("rd_lo_valid", res_valid, 1);
    check("rd_lo_oe", bus_oe, 1);
    step();
    res_ready = 1'b0;
    check("rd_end_valid", res_valid, 0);
    check("rd_end_oe", bus_oe, 0);
    check("rd_end_busy", busy, 0);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (busy && k < limit) begin
      step();
      k++;
    end
    check("wait_idle_bound", busy, 0);
  endtask

  // MAC model: answers 0x1234 about seven cycles after each start pulse.
  initial begin
    mac_done   = 1'b0;
    mac_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (mac_start) begin
        mac_starts++;
        if (mac_auto) begin
          repeat (6) @(posedge clk);
          #1;
          mac_done   = 1'b1;
          mac_result = 16'h1234;
          @(posedge clk);
          #1;
          mac_done   = 1'b0;
          mac_result = 16'h0000;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; cmd_valid = 1'b0; cmd_byte = 8'h00; res_ready = 1'b0;
    #2;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_w_we", w_we, 0);
    check("rst_x_we", x_we, 0);
    check("rst_mac_start", mac_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_byte", res_byte, 0);
    check("rst_bus_oe", bus_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("ena0_cmd_ready", cmd_ready, 0);
    ena = 1'b1;
    #1;
    check("ena_first_cycle", cmd_ready, 0);
    step();
    check("ena_cmd_ready", cmd_ready, 1);

    read_pair(16'h0000, 0);

    load_seq(8'h13, 4, 8'hA0);
    check("load_w_idle", busy, 0);
    load_seq(8'h21, 2, 8'h05);
    check("load_x_idle", busy, 0);

    drive(8'h90);
    check("nop_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    #1;
    check("nop_busy", busy, 0);
`ifndef N1_TIMEOUT_EN
    drive(8'h50);
    step();
    cmd_valid = 1'b0;
    #1;
    check("clr_nop_busy", busy, 0);
    check("clr_nop_err", err, 0);
`endif

    drive(8'h30);
    check("run_no_early_start", mac_start, 0);
    step();
    cmd_valid = 1'b0;
    #1;
    check("run_start_pulse", mac_start, 1);
    check("run_start_ready", cmd_ready, 0);
    check("run_start_busy", busy, 1);
    step();
    check("run_start_once", mac_start, 0);
    check("run_wait_ready", cmd_ready, 0);
    wait_idle(50);
    check("run_start_count", mac_starts, 1);
    read_pair(16'h1234, 3);

    // Freeze with ena low in the middle of a load
    drive(8'h13);
    step();
    drive(8'hB0);
    check("frz_addr0", wr_addr, 0);
    step();
    drive(8'hB1);
    check("frz_addr1", wr_addr, 1);
    step();
    ena = 1'b0;
    drive(8'hB2);
    for (int i = 0; i < 5; i++) begin
      check("frz_no_w_we", w_we, 0);
      check("frz_no_ready", cmd_ready, 0);
      check("frz_addr_hold", wr_addr, 2);
      step();
    end
    ena = 1'b1;
    #1;
    check("frz_resume_we", w_we, 1);
    check("frz_resume_addr", wr_addr, 2);
    check("frz_resume_data", wr_data, 8'hB2);
    step();
    drive(8'hB3);
    check("frz_last_addr", wr_addr, 3);
    step();
    cmd_valid = 1'b0;
    #1;
    check("frz_idle", busy, 0);

    load_seq(8'h1F, 16, 8'h40);
    check("full_idle", busy, 0);
    drive(8'h00);
    check("full_17th_no_we", w_we, 0);
    check("full_17th_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    #1;
    check("full_17th_nop", busy, 0);

    // Asynchronous reset while waiting on the MAC
    mac_auto = 1'b0;
    drive(8'h30);
    step();
    cmd_valid = 1'b0;
    step();
    check("wait_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", cmd_ready, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_mac_start", mac_start, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("arst_rearm", cmd_ready, 1);
    read_pair(16'h0000, 1);

`ifdef N1_TIMEOUT_EN
    drive(8'h30);
    step();
    cmd_valid = 1'b0;
    step();
    n = 0;
    while (!err && n < 100) begin
      step();
      n++;
    end
    check("to_cycles", n, 20);
    check("to_err", err, 1);
    check("to_idle", busy, 0);
    read_pair(16'hFFFF, 0);
    check("to_err_sticky", err, 1);
    drive(8'h50);
    step();
    cmd_valid = 1'b0;
    #1;
    check("to_err_clear", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
